// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer and its matching receiver.
// Holds the FSM state encoding and the idle level of the serial line.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;

  localparam logic SERIAL_IDLE = 1'b0;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-producer handshake plus serial-link outputs of the PISO serializer.
// The master modport is the producer/link side; slave is the serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic             i_en;
  logic             o_serial;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_data,
    output i_valid,
    output i_en,
    input  o_ready,
    input  o_serial,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_data,
    input  i_valid,
    input  i_en,
    output o_ready,
    output o_serial,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/bit_counter.sv
// Up-counter over 0..WIDTH-1 with synchronous clear, enable and terminal-count flag.
// Shared by the serializer and the matching serial receiver.
module bit_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_tc = (cnt_q == CntLast);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word on a valid/ready handshake
// and shifts it out one bit per enabled clock, pulsing done after the last bit.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic               i_clk,
  input logic               i_rst_n,
  piso_serializer_if.slave  bus
);
  piso_state_e      state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_shifted;
  logic             busy_q;
  logic             done_q;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;

  // Counter sits at zero while idle, so every load starts from bit 0.
  assign cnt_clr = (state_q == ST_IDLE);
  assign cnt_en  = (state_q == ST_SHIFT) && bus.i_en && !cnt_tc;

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (cnt_clr),
    .i_en    (cnt_en),
    .o_tc    (cnt_tc)
  );

  always_comb begin
    shreg_shifted = '0;
    if (MSB_FIRST) begin
      shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.i_valid) begin
            state_q <= ST_SHIFT;
            shreg_q <= bus.i_data;
            busy_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bus.i_en) begin
            if (cnt_tc) begin
              // Flush the register so the output end returns to the idle level.
              state_q <= ST_IDLE;
              shreg_q <= {WIDTH{SERIAL_IDLE}};
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              shreg_q <= shreg_shifted;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_serial = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign bus.o_busy   = busy_q;
  assign bus.o_done   = done_q;
  assign bus.o_ready  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances sharing
// clock and reset, checked against hand-written bit sequences.
module tb_piso_serializer;
  logic clk;
  logic rst_n;

  int unsigned n_checks;
  int unsigned n_fail;

  piso_serializer_if #(.WIDTH(8)) bus_a ();
  piso_serializer_if #(.WIDTH(8)) bus_b ();

  piso_serializer #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1)
  ) u_dut_msb (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_a)
  );

  piso_serializer #(
    .WIDTH     (8),
    .MSB_FIRST (1'b0)
  ) u_dut_lsb (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // seq holds the expected serial bits, first bit in seq[7].
  task automatic expect_word_a(input string tag, input logic [7:0] seq);
    for (int i = 0; i < 8; i++) begin
      check_eq({tag, "_serial"}, 32'(bus_a.o_serial), 32'(seq[7-i]));
      check_eq({tag, "_busy"}, 32'(bus_a.o_busy), 32'd1);
      check_eq({tag, "_ready"}, 32'(bus_a.o_ready), 32'd0);
      tick();
    end
    check_eq({tag, "_done"}, 32'(bus_a.o_done), 32'd1);
    check_eq({tag, "_busy_end"}, 32'(bus_a.o_busy), 32'd0);
    check_eq({tag, "_ready_end"}, 32'(bus_a.o_ready), 32'd1);
    check_eq({tag, "_serial_end"}, 32'(bus_a.o_serial), 32'd0);
  endtask

  task automatic expect_word_b(input string tag, input logic [7:0] seq);
    for (int i = 0; i < 8; i++) begin
      check_eq({tag, "_serial"}, 32'(bus_b.o_serial), 32'(seq[7-i]));
      check_eq({tag, "_busy"}, 32'(bus_b.o_busy), 32'd1);
      tick();
    end
    check_eq({tag, "_done"}, 32'(bus_b.o_done), 32'd1);
    check_eq({tag, "_busy_end"}, 32'(bus_b.o_busy), 32'd0);
    check_eq({tag, "_ready_end"}, 32'(bus_b.o_ready), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    bus_a.i_data  = '0;
    bus_a.i_valid = 1'b0;
    bus_a.i_en    = 1'b1;
    bus_b.i_data  = '0;
    bus_b.i_valid = 1'b0;
    bus_b.i_en    = 1'b1;

    // Asynchronous reset asserted mid-cycle takes effect without a clock edge.
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_serial", 32'(bus_a.o_serial), 32'd0);
    check_eq("rst_busy", 32'(bus_a.o_busy), 32'd0);
    check_eq("rst_done", 32'(bus_a.o_done), 32'd0);
    check_eq("rst_ready", 32'(bus_a.o_ready), 32'd1);
    check_eq("rst_ready_b", 32'(bus_b.o_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic MSB-first word 8'hA5.
    bus_a.i_data  = 8'hA5;
    bus_a.i_valid = 1'b1;
    tick();
    bus_a.i_valid = 1'b0;
    bus_a.i_data  = 8'h00;
    expect_word_a("basic", 8'b1010_0101);
    tick();
    check_eq("basic_done_width", 32'(bus_a.o_done), 32'd0);

    // LSB-first word 8'h0D.
    bus_b.i_data  = 8'h0D;
    bus_b.i_valid = 1'b1;
    tick();
    bus_b.i_valid = 1'b0;
    expect_word_b("lsb", 8'b1011_0000);
    tick();
    check_eq("lsb_done_width", 32'(bus_b.o_done), 32'd0);

    // Stall of three cycles while the third bit is on the line.
    bus_a.i_data  = 8'hA5;
    bus_a.i_valid = 1'b1;
    tick();
    bus_a.i_valid = 1'b0;
    begin
      logic [7:0] seq;
      seq = 8'b1010_0101;
      for (int i = 0; i < 8; i++) begin
        check_eq("stall_serial", 32'(bus_a.o_serial), 32'(seq[7-i]));
        if (i == 2) begin
          bus_a.i_en = 1'b0;
          for (int s = 0; s < 3; s++) begin
            tick();
            check_eq("stall_hold", 32'(bus_a.o_serial), 32'd1);
            check_eq("stall_busy", 32'(bus_a.o_busy), 32'd1);
            check_eq("stall_no_done", 32'(bus_a.o_done), 32'd0);
          end
          bus_a.i_en = 1'b1;
        end
        tick();
      end
      check_eq("stall_done", 32'(bus_a.o_done), 32'd1);
    end
    tick();

    // Back-to-back: FF accepted, 00 presented immediately; accepted on the done cycle.
    bus_a.i_data  = 8'hFF;
    bus_a.i_valid = 1'b1;
    tick();
    bus_a.i_data  = 8'h00;
    expect_word_a("b2b_first", 8'b1111_1111);
    tick();
    bus_a.i_valid = 1'b0;
    expect_word_a("b2b_second", 8'b0000_0000);
    tick();

    // Reset mid-word after four bits, then a fresh word.
    bus_a.i_data  = 8'hA5;
    bus_a.i_valid = 1'b1;
    tick();
    bus_a.i_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("abort_busy_before", 32'(bus_a.o_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(bus_a.o_busy), 32'd0);
    check_eq("abort_serial", 32'(bus_a.o_serial), 32'd0);
    check_eq("abort_ready", 32'(bus_a.o_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("abort_no_done", 32'(bus_a.o_done), 32'd0);
      check_eq("abort_idle_busy", 32'(bus_a.o_busy), 32'd0);
    end
    bus_a.i_data  = 8'h3C;
    bus_a.i_valid = 1'b1;
    tick();
    bus_a.i_valid = 1'b0;
    expect_word_a("after_rst", 8'b0011_1100);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter for the enable-gated register path.
- Accepts a WIDTH-bit word through a valid/ready handshake, then shifts it out one bit per enabled clock.
- A downstream serial-in capture chain reassembles the word; that chain is built from enabled D flip-flops sampling o_serial when o_busy is high.
- Sits between a parallel producer and the single-wire link.

Parameters:
- WIDTH, 8, word width in bits (2 or more).
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_data  input  WIDTH  parallel word to send.
- i_valid  input  1  producer has a word on i_data.
- o_ready  output  1  block can accept a word this cycle.
- i_en  input  1  shift enable; a low level stalls the shift.
- o_serial  output  1  serial data bit.
- o_busy  output  1  o_serial carries a valid data bit.
- o_done  output  1  one-cycle pulse after the last bit is sent.

Behaviour:
- Reset (async assert, sync release): state=IDLE, shift register=0, bit counter=0, o_serial=0, o_busy=0, o_done=0, o_ready=1.
- Reset mid-word aborts the word immediately. No partial-word indication is given.
- States: IDLE, SHIFT.
- o_ready=1 only in IDLE. It is decoded from state only and never depends on i_valid.
- Handshake: on a rising edge with state=IDLE and i_valid=1:
  - load i_data into the shift register, counter=0, go to SHIFT;
  - i_en is ignored for the load.
- i_valid while in SHIFT is ignored. The producer holds i_data/i_valid until it sees o_ready=1.
- In SHIFT:
  - o_busy=1.
  - o_serial = shift-register bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0).
  - First bit appears in the cycle right after the accept edge (latency 1).
- Each rising edge in SHIFT with i_en=1:
  - if counter < WIDTH-1: shift by one toward the output end, fill with 0, counter+1;
  - if counter == WIDTH-1: go to IDLE, o_serial=0, o_busy=0, o_done=1 for exactly one cycle.
- Rising edge in SHIFT with i_en=0: nothing changes; o_serial and the counter hold (stall of any length).
- o_done is registered and is high during the first IDLE cycle only. An accept on that same cycle is legal, so o_done and the next word's load coincide.
- Throughput with i_en held high: one word per WIDTH+1 cycles.
- Counter width is clog2(WIDTH). The counter never wraps, because it resets on load.
- All outputs are registered except o_ready, which is decoded from the state register.
- No X is propagated from i_data when i_valid=0.

Decomposition:
- Shared include piso_defs.vh holds:
  - state encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - the idle-level constant SERIAL_IDLE=1'b0.
- One sub-module, bit_counter: a clog2(WIDTH)-bit counter with clear, enable and a terminal-count flag at WIDTH-1. Reusable for the matching receiver.
- The FSM and the shift register stay in piso_serializer.

Test Plan:
- Reset: assert i_rst_n=0 mid-cycle -> o_serial=0, o_busy=0, o_done=0, o_ready=1 immediately, without waiting for a clock edge.
- Basic word (WIDTH=8, MSB_FIRST=1): i_data=8'hA5, i_valid=1 for one cycle, i_en=1 -> o_serial over the next 8 cycles = 1,0,1,0,0,1,0,1 with o_busy=1; then o_done=1 for 1 cycle, o_busy=0, o_ready=1.
- LSB-first: MSB_FIRST=0, i_data=8'h0D -> o_serial = 1,0,1,1,0,0,0,0.
- Stall: 8'hA5 sent with i_en dropped low for 3 cycles after the 3rd bit -> o_serial holds 1 for those 3 cycles (bit 3 stays on the output throughout the stall); the remaining bits follow; o_done occurs 3 cycles later than in the basic test.
- Back-to-back: i_valid held high with 8'hFF, then 8'h00 -> the second load happens on the o_done cycle; the pattern is 8 ones, 1 idle cycle (o_serial=0, o_busy=0), 8 zeros; i_valid during SHIFT is not accepted.
- Reset mid-word: i_rst_n=0 after 4 bits of 8'hA5 -> o_busy=0 at once, no o_done pulse; after release, a new word 8'h3C is sent intact as 0,0,1,1,1,1,0,0.
